// File: rtl/score_award_scheduler_if.sv
// Scoring-event handshakes, frame pacing and award output
// shared between game logic, scheduler and scoredisplay.
interface score_award_scheduler_if;
  logic        frame_tick;
  logic [3:0]  level;
  logic        clear_valid;
  logic [2:0]  clear_lines;
  logic        clear_ready;
  logic        drop_valid;
  logic [4:0]  drop_cells;
  logic        drop_ready;
  logic [15:0] scorewire;
  logic        busy;
  logic        dropped_evt;

  modport master (
    output frame_tick, level,
    output clear_valid, clear_lines,
    output drop_valid, drop_cells,
    input  clear_ready, drop_ready,
    input  scorewire, busy, dropped_evt
  );

  modport slave (
    input  frame_tick, level,
    input  clear_valid, clear_lines,
    input  drop_valid, drop_cells,
    output clear_ready, drop_ready,
    output scorewire, busy, dropped_evt
  );
endinterface

// File: rtl/score_award_scheduler.sv
// Arbitrates line-clear / drop-bonus events into a level-scaled
// award FIFO and releases one award pulse per paced frame.
module score_award_scheduler #(
  parameter int FIFO_DEPTH = 4,
  parameter int GAP_FRAMES = 2
) (
  input logic                    clk_25_175,
  input logic                    reset,
  score_award_scheduler_if.slave bus
);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int NW = $clog2(FIFO_DEPTH + 1);
  localparam int CW = (GAP_FRAMES > 0) ? $clog2(GAP_FRAMES + 1) : 1;

  typedef enum logic [1:0] {
    IDLE,
    EMIT,
    HOLD
  } state_t;

  state_t state, state_n;
  logic [CW-1:0] hold_cnt, hold_n;

  logic [15:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [NW-1:0] count;

  logic        last_drop;
  logic        full, empty;
  logic        clear_hs, drop_hs;
  logic        clear_ok, push, pop;
  logic [10:0] base;
  logic [4:0]  scale;
  logic [15:0] award;
  logic [15:0] score_q;
  logic        dropped_q;

  assign full  = count == NW'(FIFO_DEPTH);
  assign empty = count == '0;

  // Loser of the last handshake wins a tie.
  assign bus.clear_ready = !full &&
    !(bus.drop_valid && !last_drop);
  assign bus.drop_ready = !full &&
    !(bus.clear_valid && last_drop);

  assign clear_hs = bus.clear_valid & bus.clear_ready;
  assign drop_hs  = bus.drop_valid & bus.drop_ready;

  assign clear_ok = (bus.clear_lines != 3'd0) &&
    (bus.clear_lines <= 3'd4);

  always_comb begin
    base = 11'd0;
    unique case (bus.clear_lines)
      3'd1:    base = 11'd40;
      3'd2:    base = 11'd100;
      3'd3:    base = 11'd300;
      3'd4:    base = 11'd1200;
      default: base = 11'd0;
    endcase
  end

  assign scale = {1'b0, bus.level} + 5'd1;

  assign award = clear_hs ?
    16'(base) * 16'(scale) :
    16'(bus.drop_cells) * 16'(scale);

  assign push = (clear_hs & clear_ok) |
    (drop_hs & (bus.drop_cells != 5'd0));

  always_comb begin
    state_n = state;
    hold_n  = hold_cnt;
    pop     = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.frame_tick && !empty) begin
          pop     = 1'b1;
          state_n = EMIT;
        end
      end
      EMIT: begin
        if (GAP_FRAMES == 0) begin
          state_n = IDLE;
        end else begin
          state_n = HOLD;
          hold_n  = CW'(GAP_FRAMES);
        end
      end
      HOLD: begin
        // The tick that expires the holdoff cannot emit.
        if (bus.frame_tick) begin
          hold_n = hold_cnt - CW'(1);
          if (hold_cnt == CW'(1))
            state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_25_175) begin
    if (!reset) begin
      state     <= IDLE;
      hold_cnt  <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      last_drop <= 1'b1;
      score_q   <= '0;
      dropped_q <= 1'b0;
    end else begin
      state    <= state_n;
      hold_cnt <= hold_n;
      count    <= count + NW'(push) - NW'(pop);
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      if (clear_hs)
        last_drop <= 1'b0;
      else if (drop_hs)
        last_drop <= 1'b1;
      if (clear_hs && !clear_ok)
        dropped_q <= 1'b1;
      score_q <= pop ? mem[rd_ptr] : '0;
    end
  end

  always_ff @(posedge clk_25_175) begin
    if (push)
      mem[wr_ptr] <= award;
  end

  assign bus.scorewire   = score_q;
  assign bus.dropped_evt = dropped_q;
  assign bus.busy        = !empty || (state != IDLE);
endmodule

// File: tb/tb_score_award_scheduler.sv
// Bench for score_award_scheduler: directed scenarios plus
// randomized traffic against a queue-based award model.
module tb_score_award_scheduler;
  localparam int DEPTH = 4;
  localparam int GAP   = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int tests = 0;
  int fails = 0;

  score_award_scheduler_if bus();

  score_award_scheduler #(
    .FIFO_DEPTH(DEPTH),
    .GAP_FRAMES(GAP)
  ) dut (
    .clk_25_175(clk),
    .reset(reset),
    .bus(bus.slave)
  );

  always #20 clk = ~clk;

  int q[$];
  bit m_lg_drop = 1'b1;
  int m_hold = 0;
  bit m_emit = 1'b0;
  int m_sw = 0;
  bit m_dropped = 1'b0;
  bit mv = 1'b0;

  function automatic int clear_base(input int l);
    case (l)
      1: return 40;
      2: return 100;
      3: return 300;
      4: return 1200;
      default: return 0;
    endcase
  endfunction

  task automatic chk(input string n,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask

  // One clock cycle: drive, compare against the model, advance the model.
  task automatic step(input bit r, input bit t,
                      input int l,
                      input bit cv, input int cl,
                      input bit dv, input int dc);
    bit full, ecr, edr, popnow;
    int nsw;
    @(negedge clk);
    reset           = r;
    bus.frame_tick  = t;
    bus.level       = 4'(l);
    bus.clear_valid = cv;
    bus.clear_lines = 3'(cl);
    bus.drop_valid  = dv;
    bus.drop_cells  = 5'(dc);
    #1;
    full = q.size() >= DEPTH;
    ecr = !full && !(dv && !m_lg_drop);
    edr = !full && !(cv && m_lg_drop);
    if (mv) begin
      chk("clear_ready", bus.clear_ready, ecr);
      chk("drop_ready", bus.drop_ready, edr);
      chk("scorewire", bus.scorewire, m_sw);
      chk("busy", bus.busy,
          (q.size() != 0) || m_emit || (m_hold > 0));
      chk("dropped_evt", bus.dropped_evt, m_dropped);
    end
    if (!r) begin
      q.delete();
      m_lg_drop = 1'b1;
      m_hold = 0;
      m_emit = 1'b0;
      m_sw = 0;
      m_dropped = 1'b0;
      mv = 1'b1;
    end else begin
      nsw = 0;
      popnow = 1'b0;
      if (m_emit) begin
        m_emit = 1'b0;
        m_hold = GAP;
      end else if (t) begin
        if (m_hold > 0) m_hold--;
        else if (q.size() > 0) popnow = 1'b1;
      end
      if (popnow) begin
        nsw = q.pop_front();
        m_emit = 1'b1;
      end
      if (cv && ecr) begin
        m_lg_drop = 1'b0;
        if (cl >= 1 && cl <= 4) q.push_back(clear_base(cl) * (l + 1));
        else m_dropped = 1'b1;
      end else if (dv && edr) begin
        m_lg_drop = 1'b1;
        if (dc != 0) q.push_back(dc * (l + 1));
      end
      m_sw = nsw;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) step(1, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic tick_check(input string n, input int exp);
    step(1, 1, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    chk(n, bus.scorewire, exp);
    idle(2);
  endtask

  initial begin
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    chk("rst_scorewire", bus.scorewire, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_dropped", bus.dropped_evt, 0);

    // Tie right after reset: clear first, then drop.
    step(1, 0, 0, 1, 1, 1, 10);
    chk("tie_clear_ready", bus.clear_ready, 1);
    chk("tie_drop_ready", bus.drop_ready, 0);
    step(1, 0, 0, 0, 0, 1, 10);
    chk("second_drop_ready", bus.drop_ready, 1);
    idle(1);
    tick_check("emit_40", 40);
    tick_check("hold_a", 0);
    tick_check("hold_b", 0);
    tick_check("emit_drop10", 10);
    tick_check("hold_c", 0);
    tick_check("hold_d", 0);
    chk("idle_busy", bus.busy, 0);

    // Level scaling.
    step(1, 0, 3, 1, 4, 0, 0);
    step(1, 0, 15, 1, 4, 0, 0);
    step(1, 0, 2, 0, 0, 1, 10);
    tick_check("emit_4800", 4800);
    tick_check("h1", 0);
    tick_check("h2", 0);
    tick_check("emit_19200", 19200);
    tick_check("h3", 0);
    tick_check("h4", 0);
    tick_check("emit_30", 30);
    tick_check("h5", 0);
    tick_check("h6", 0);

    // Five back-to-back pushes against a depth-4 FIFO.
    repeat (5) step(1, 0, 0, 1, 1, 0, 0);
    chk("full_stall", bus.clear_ready, 0);
    step(1, 1, 0, 1, 1, 0, 0);
    @(posedge clk);
    #1;
    chk("burst_tick1", bus.scorewire, 40);
    step(1, 0, 0, 1, 1, 0, 0);
    chk("after_pop_ready", bus.clear_ready, 1);
    idle(2);
    for (int k = 2; k <= 15; k++)
      tick_check($sformatf("burst_tick%0d", k),
                 (k % 3 == 1 && k <= 13) ? 40 : 0);
    chk("burst_done_busy", bus.busy, 0);

    // Invalid line counts are swallowed and flagged.
    step(1, 0, 0, 1, 0, 0, 0);
    idle(1);
    chk("dropped_set", bus.dropped_evt, 1);
    step(1, 0, 0, 1, 5, 0, 0);
    idle(1);
    tick_check("invalid_no_emit", 0);
    chk("dropped_sticky", bus.dropped_evt, 1);

    // Reset during HOLD with awards still queued.
    repeat (4) step(1, 0, 0, 1, 2, 0, 0);
    tick_check("pre_reset_100", 100);
    step(0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    chk("mid_rst_scorewire", bus.scorewire, 0);
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_clear_ready", bus.clear_ready, 1);
    chk("mid_rst_drop_ready", bus.drop_ready, 1);
    chk("mid_rst_dropped", bus.dropped_evt, 0);
    idle(1);
    tick_check("post_rst_a", 0);
    tick_check("post_rst_b", 0);

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      int cl;
      cl = ($urandom_range(0, 7) == 0) ?
           int'($urandom_range(0, 7)) : int'($urandom_range(1, 4));
      step(($urandom_range(0, 299) != 0),
           ($urandom_range(0, 3) == 0),
           int'($urandom_range(0, 15)),
           $urandom_range(0, 1) == 1, cl,
           $urandom_range(0, 2) == 0,
           int'($urandom_range(0, 31)));
    end
    idle(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/score_award_scheduler.md
Name: score_award_scheduler

Overview:
Sits between the game-logic core and scoredisplay. It accepts scoring events from two requesters: line clears, and hard-drop bonus cells. It converts each event to a point award scaled by level and buffers awards in a 4-entry FIFO. It releases at most one award per paced frame as a single-cycle pulse on scorewire, so the display's roll-up counter drains each award visibly before the next one arrives.

Parameters:
FIFO_DEPTH, 4, award FIFO entries (power of 2)
GAP_FRAMES, 2, frame_tick pulses to hold off after each emission (0 = no holdoff)

Ports:
clk_25_175  in  1  pixel clock, single clock domain
reset  in  1  synchronous, active-low; all state cleared on the clock edge where reset==0
frame_tick  in  1  one-cycle pulse per frame (vsync start)
level  in  4  current level, 0..15, sampled at handshake
clear_valid  in  1  line-clear request
clear_lines  in  3  lines cleared, valid 1..4
clear_ready  out  1  line-clear accept
drop_valid  in  1  drop-bonus request
drop_cells  in  5  cells dropped, 0..31
drop_ready  out  1  drop-bonus accept
scorewire  out  16  award pulse to scoredisplay; 0 when idle
busy  out  1  FIFO non-empty or state != IDLE
dropped_evt  out  1  sticky: invalid clear_lines was accepted

Behaviour:
- Reset values: scorewire=0, busy=0, dropped_evt=0, FIFO empty, state=IDLE, holdoff counter=0, last_grant=DROP (so clear wins the first tie).
- Arbitration and push, one push per cycle max:
  - ready outputs are combinational. Both are 0 when the FIFO is full.
  - If only one valid is high, that requester gets ready=1.
  - If both are high, the requester not in last_grant gets ready=1 and the other gets 0. last_grant updates on each handshake.
  - Handshake = valid & ready. The award is written to the FIFO tail at the next edge; count increments by 1.
- Award arithmetic, computed combinationally at handshake, 16-bit unsigned:
  - clear: base(1)=40, base(2)=100, base(3)=300, base(4)=1200. award = base*(level+1). Maximum 19200, no overflow possible.
  - drop: award = drop_cells*(level+1). Maximum 496.
  - clear_lines of 0 or 5..7: the handshake still completes and last_grant updates, but nothing is pushed and dropped_evt is set to 1.
  - drop_cells==0: the handshake completes and nothing is pushed.
- Emission FSM, states IDLE, EMIT, HOLD:
  - IDLE: on frame_tick with the FIFO non-empty -> EMIT. The head is popped at that edge and registered into scorewire.
  - EMIT, exactly 1 cycle: scorewire = award. Next edge: scorewire=0. Go to HOLD with counter=GAP_FRAMES, or to IDLE if GAP_FRAMES==0.
  - HOLD: each frame_tick decrements the counter. The tick that reaches 0 returns to IDLE and is not itself eligible to emit. The next frame_tick is.
  - frame_tick while in EMIT is ignored.
  - Latency: frame_tick at cycle T -> scorewire nonzero at T+1 only.
- Push and pop in the same cycle are both honoured; count is unchanged. Full is evaluated before the pop, so there is no ready bypass when full.
- FIFO pointers wrap modulo FIFO_DEPTH. Order is strictly FIFO across both requesters.
- Reset asserted mid-EMIT or mid-HOLD: the next edge forces scorewire=0 and discards all queued awards.
- busy = (count!=0) | (state!=IDLE).

Test Plan:
- Reset, then level=0, clear_valid with lines=1 for 1 cycle; frame_tick -> scorewire=40 for exactly one cycle, the cycle after the tick; busy drops after the holdoff completes.
- level=3, lines=4 -> scorewire=4800. level=15, lines=4 -> 19200. level=2, drop_cells=10 -> 30.
- clear_valid and drop_valid both high on the first cycle after reset -> clear accepted first (clear_ready=1, drop_ready=0). Next cycle drop accepted. Emissions occur in that order on successive eligible ticks.
- GAP_FRAMES=2, push 5 awards back-to-back -> 5th push stalls (ready=0) until the first pop. Emissions occur on ticks 1, 4, 7, 10, 13. No scorewire pulse between those ticks.
- clear_lines=0 handshake -> nothing emitted and dropped_evt=1 until reset. clear_lines=5 behaves the same.
- Reset pulsed during HOLD with 3 awards queued -> scorewire=0, busy=0 and both readies=1 on the next cycle; subsequent ticks emit nothing.
